// File: rtl/prio_code_decoder_if.sv
// Producer handshake and decoded-output bundle for prio_code_decoder.
// The err signal exists only when PRIO_DEC_ERR_EN is defined.
interface prio_code_decoder_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_code;
  logic          in_none;
  logic [7:0]    sel;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
`ifdef PRIO_DEC_ERR_EN
  logic          err;
`endif

  // Producer / observer side
  modport master (
    output in_valid, in_code, in_none,
    input  in_ready, sel, busy, done, count
`ifdef PRIO_DEC_ERR_EN
    , input err
`endif
  );

  // Decoder side
  modport slave (
    input  in_valid, in_code, in_none,
    output in_ready, sel, busy, done, count
`ifdef PRIO_DEC_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/prio_code_decoder.sv
// Queued 3-to-8 decoder: replays each FIFO'd priority code as a one-hot sel held
// for HOLD cycles plus one idle gap. Optional err pulse under PRIO_DEC_ERR_EN.
module prio_code_decoder #(
  parameter int unsigned HOLD  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  prio_code_decoder_if.slave   bus
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam logic [7:0]  HOLD_M1  = 8'(HOLD - 1);
  localparam bit          HOLD_ONE = (HOLD == 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_hold,  w_hold_nxt;
  logic [7:0]    r_sel,   w_sel_nxt;
  logic          r_done,  w_done_nxt;
  logic          r_busy;
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_ready, w_push, w_pop, w_empty;
  logic [3:0]    w_head;

  // Occupancy-only ready: a full FIFO refuses even when a pop happens alongside
  assign w_ready = (r_count < CW'(DEPTH));
  assign w_push  = bus.in_valid && w_ready;
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.in_none, bus.in_code};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state and registered-output values
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_sel_nxt   = r_sel;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_DRIVE;
          w_hold_nxt  = HOLD_M1;
          w_sel_nxt   = w_head[3] ? 8'h00 : (8'd1 << w_head[2:0]);
          w_done_nxt  = HOLD_ONE;
        end else begin
          w_state_nxt = S_IDLE;
          w_sel_nxt   = 8'h00;
        end
      end
      S_DRIVE: begin
        if (r_hold == 8'd0) begin
          w_state_nxt = S_GAP;
          w_sel_nxt   = 8'h00;
        end else begin
          w_hold_nxt = r_hold - 8'd1;
          w_done_nxt = (r_hold == 8'd1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= 8'd0;
      r_sel   <= 8'h00;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_sel   <= w_sel_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (r_state != S_IDLE) || !w_empty;
    end
  end

`ifdef PRIO_DEC_ERR_EN
  logic r_err;

  // Flags the first hold cycle of an in_none entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_pop && w_head[3];
  end

  assign bus.err = r_err;
`endif

  assign bus.in_ready = w_ready;
  assign bus.sel      = r_sel;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.count    = r_count;
endmodule
